mips_reg_dump: RTL and testbench

Debug read-out engine for the pipelined MIPS32 core: once the core is halted, it walks a contiguous range of the register file through a dedicated read port and streams each 32-bit word out over a valid/ready interface. It is the read-back counterpart to the program/register preload path. It lets benches and on-chip debug logic extract results without hierarchical references into the core.

---
 rtl/mips_reg_dump.sv | 190 +++++++++++++++++++
 tb/tb_mips_reg_dump.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_reg_dump.sv
`default_nettype none
// =============================================================================
// mips_reg_dump : streams a contiguous register range of a halted core over
// valid/ready. Define DUMP_CHECKSUM_EN to append an XOR checksum word.
// Revision : 1.0
// =============================================================================
module mips_reg_dump #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] first_reg,
   input  logic [AW-1:0] last_reg,
   input  logic          core_halted,
   output logic [AW-1:0] rf_raddr,
   input  logic [DW-1:0] rf_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [AW:0] c_nregs = (AW+1)'(NREGS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_SEND = 3'd2,
`ifdef DUMP_CHECKSUM_EN
      S_CSUM = 3'd3,
`endif
      S_DONE = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] cur_q, cur_d;
   logic [AW-1:0] lastq_q, lastq_d;
   logic [DW-1:0] data_q, data_d;
   logic          valid_q, valid_d;
   logic          last_q, last_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
`ifdef DUMP_CHECKSUM_EN
   logic [DW-1:0] csum_q, csum_d;
`endif

   logic w_hs;
   logic w_bad_req;
   logic w_load_last;

   assign w_hs      = valid_q & out_ready;
   assign w_bad_req = ~core_halted | (first_reg > last_reg) | ({1'b0, last_reg} >= c_nregs);
`ifdef DUMP_CHECKSUM_EN
   assign w_load_last = 1'b0;
`else
   assign w_load_last = (ptr_q == lastq_q);
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cur_d   = cur_q;
      lastq_d = lastq_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      err_d   = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (w_bad_req) begin
                  err_d = 1'b1;
               end else begin
                  ptr_d   = first_reg;
                  lastq_d = last_reg;
                  busy_d  = 1'b1;
                  state_d = S_LOAD;
`ifdef DUMP_CHECKSUM_EN
                  csum_d  = '0;
`endif
               end
            end
         end
         S_LOAD, S_SEND: begin
            if (!core_halted) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (state_q == S_LOAD || (w_hs && cur_q != lastq_q)) begin
`ifdef DUMP_CHECKSUM_EN
               if (state_q == S_SEND) csum_d = csum_q ^ data_q;
`endif
               // Reload on the handshake edge itself so the stream has no bubble.
               data_d  = rf_rdata;
               cur_d   = ptr_q;
               ptr_d   = ptr_q + 1'b1;
               valid_d = 1'b1;
               last_d  = w_load_last;
               state_d = S_SEND;
            end else if (w_hs) begin
`ifdef DUMP_CHECKSUM_EN
               csum_d  = csum_q ^ data_q;
               data_d  = csum_q ^ data_q;
               last_d  = 1'b1;
               state_d = S_CSUM;
`else
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = S_DONE;
`endif
            end
         end
`ifdef DUMP_CHECKSUM_EN
         S_CSUM: begin
            if (!core_halted) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (w_hs) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cur_q   <= '0;
         lastq_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cur_q   <= cur_d;
         lastq_q <= lastq_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign rf_raddr  = ptr_q;
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mips_reg_dump.sv
`default_nettype none
// =============================================================================
// tb_mips_reg_dump : directed scoreboard bench for mips_reg_dump.
// Revision : 1.0
// =============================================================================
module tb_mips_reg_dump;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NREGS = 32;
`ifdef DUMP_CHECKSUM_EN
   localparam int c_extra = 1;
`else
   localparam int c_extra = 0;
`endif

   logic          clk1 = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] first_reg = '0;
   logic [AW-1:0] last_reg = '0;
   logic          core_halted = 1'b0;
   logic [AW-1:0] rf_raddr;
   logic [DW-1:0] rf_rdata;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          err;

   logic [DW-1:0] rf [NREGS];
   logic [DW:0]   sb [$];

   int n_pass = 0, n_total = 0, n_fail = 0;
   int done_cnt = 0, err_cnt = 0, both_cnt = 0, valid_cnt = 0;
   int pat [4] = '{1, 0, 0, 1};

   mips_reg_dump #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .start      (start),
      .first_reg  (first_reg),
      .last_reg   (last_reg),
      .core_halted(core_halted),
      .rf_raddr   (rf_raddr),
      .rf_rdata   (rf_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   assign rf_rdata = rf[rf_raddr];

   always #5 clk1 = ~clk1;

   always @(posedge clk1) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
      if (out_valid) valid_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_dump(input int f, input int l);
      logic [DW-1:0] cs;
      logic          lst;
      cs = '0;
      for (int i = f; i <= l; i++) begin
         cs = cs ^ rf[i];
`ifdef DUMP_CHECKSUM_EN
         lst = 1'b0;
`else
         lst = (i == l);
`endif
         sb.push_back({lst, rf[i]});
      end
`ifdef DUMP_CHECKSUM_EN
      sb.push_back({1'b1, cs});
`endif
   endtask

   // Called at a negedge; returns at the negedge after start was sampled (LOAD).
   task automatic start_dump(input int f, input int l);
      first_reg = AW'(f);
      last_reg  = AW'(l);
      start     = 1'b1;
      @(negedge clk1);
      start = 1'b0;
      check("load_busy", busy, 1);
      check("load_no_valid", out_valid, 0);
      push_dump(f, l);
   endtask

   task automatic drain(input int mode, input int max_hs,
                        output int first_hs, output int last_hs, output int hs);
      int          cyc;
      logic [DW:0] e;
      cyc = 0; hs = 0; first_hs = -1; last_hs = -1;
      while (sb.size() > 0 && hs < max_hs && cyc < 200) begin
         out_ready = (mode == 0) ? 1'b1 : (pat[cyc % 4] != 0);
         if (out_valid && out_ready) begin
            e = sb.pop_front();
            check("word_data", out_data, e[DW-1:0]);
            check("word_last", out_last, e[DW]);
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            hs++;
         end else if (out_valid) begin
            check("stall_hold", out_data, sb[0][DW-1:0]);
         end
         cyc++;
         @(negedge clk1);
      end
      out_ready = 1'b0;
      check("drain_timeout", (cyc < 200), 1);
   endtask

   task automatic finish_checks();
      check("done_pulse", done, 1);
      check("done_no_err", err, 0);
      check("done_valid_low", out_valid, 0);
      @(negedge clk1);
      check("done_single", done, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      int fh, lh, hs, d0, e0, v0;
      for (int k = 0; k < NREGS; k++) rf[k] = DW'(k);
      rf[1] = 32'd10; rf[2] = 32'd20; rf[3] = 32'd25; rf[4] = 32'd30; rf[5] = 32'd55;

      repeat (2) @(negedge clk1);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_data", out_data, 0);
      check("rst_raddr", rf_raddr, 0);
      rst_n = 1'b1;
      core_halted = 1'b1;
      @(negedge clk1);

      // full-rate dump 0..5
      d0 = done_cnt;
      start_dump(0, 5);
      drain(0, 100, fh, lh, hs);
      check("full_count", hs, 6 + c_extra);
      check("first_latency", fh, 1);
      check("full_rate", lh - fh, 5 + c_extra);
      finish_checks();
      check("full_done_cnt", done_cnt - d0, 1);

      // backpressured dump 0..5
      start_dump(0, 5);
      drain(1, 100, fh, lh, hs);
      check("stall_count", hs, 6 + c_extra);
      check("stall_sb_empty", sb.size(), 0);
      finish_checks();

      // rejected requests: not halted, then inverted range
      for (int t = 0; t < 2; t++) begin
         e0 = err_cnt; v0 = valid_cnt;
         core_halted = (t == 1);
         first_reg = (t == 1) ? 5'd6 : 5'd0;
         last_reg  = (t == 1) ? 5'd2 : 5'd5;
         start = 1'b1;
         @(negedge clk1);
         start = 1'b0;
         check("rej_err", err, 1);
         check("rej_busy", busy, 0);
         @(negedge clk1);
         check("rej_err_pulse", err, 0);
         repeat (3) @(negedge clk1);
         check("rej_err_cnt", err_cnt - e0, 1);
         check("rej_no_valid", valid_cnt - v0, 0);
      end
      core_halted = 1'b1;

      // single-word dump at the top register
      start_dump(31, 31);
      drain(0, 100, fh, lh, hs);
      check("single_count", hs, 1 + c_extra);
      finish_checks();
      check("raddr_wrap", rf_raddr, 0);

      // abort after two handshakes
      d0 = done_cnt;
      start_dump(0, 5);
      drain(0, 2, fh, lh, hs);
      check("abort_hs", hs, 2);
      core_halted = 1'b0;
      @(negedge clk1);
      check("abort_valid", out_valid, 0);
      check("abort_err", err, 1);
      check("abort_busy", busy, 0);
      core_halted = 1'b1;
      sb.delete();
      repeat (4) @(negedge clk1);
      check("abort_no_done", done_cnt - d0, 0);

      // reset mid-dump, then a fresh dump
      start_dump(0, 5);
      drain(0, 2, fh, lh, hs);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_last", out_last, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_raddr", rf_raddr, 0);
      check("mid_rst_err", err, 0);
      sb.delete();
      @(negedge clk1);
      rst_n = 1'b1;
      @(negedge clk1);
      start_dump(0, 5);
      drain(0, 100, fh, lh, hs);
      check("post_rst_count", hs, 6 + c_extra);
      finish_checks();

      check("err_done_exclusive", both_cnt, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
